// File: rtl/serial_receiver.sv
// Purpose: deserializes idle-high start/data/stop frames (LSB first) from rx into a FWFT word FIFO.
// Latency: word visible on data_out 2 + CLKS_PER_BIT/2 + (DATA_W+1)*CLKS_PER_BIT + 1 cycles after the rx fall.
// Backpressure: none on the line; a good word arriving while the FIFO is full and not popped is dropped with an overflow pulse.
// Option: define RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.

// Purpose: generic synchronous FIFO, first-word-fall-through, simultaneous push/pop honoured even when full.
// Latency: a pushed word is visible on rd_dat the cycle after the push.
// Backpressure: wr_rdy low when full unless a pop is accepted in the same cycle.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     core_clk,
    input  logic                     arst_n,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     wr_rdy,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    // Handshake decode: a pop frees the slot the same cycle, so a full FIFO can still accept.
    always_comb begin
        full    = (level == LVL_FULL);
        rd_vld  = (level != '0);
        wr_rdy  = !full || (rd_rdy && rd_vld);
        push_ok = wr_vld && wr_rdy;
        pop_ok  = rd_rdy && rd_vld;
        rd_dat  = rd_vld ? mem[rd_ptr] : '0;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage array; contents need no reset because rd_dat is masked while empty.
    always_ff @(posedge core_clk) begin
        if (push_ok) mem[wr_ptr] <= wr_dat;
    end
endmodule

module serial_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          wb_clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             data_out,
    output logic                          valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overflow,
    output logic                          parity_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [1:0]        sync;
    logic              rxs;
    logic              push;
    logic              ferr_nxt;
    logic              perr_nxt;
    logic              par_ok;
    logic              fifo_wr_rdy;
`ifdef RX_PARITY_EN
    logic              par_bit, par_bit_nxt;
`endif

    assign rxs  = sync[1];
    assign busy = (state != IDLE);

    // Two-flop synchronizer for the asynchronous line; resets to idle-high.
    always_ff @(posedge wb_clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], rx};
    end

    // Frame FSM state, bit counter, bit index and shift register.
    always_ff @(posedge wb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            shreg <= shreg_nxt;
        end
    end

`ifdef RX_PARITY_EN
    // Captured parity bit, held until the stop-bit decision.
    always_ff @(posedge wb_clk or negedge rst_n) begin
        if (!rst_n) par_bit <= 1'b0;
        else        par_bit <= par_bit_nxt;
    end

    // Even parity: data bits plus parity bit must XOR to zero.
    always_comb begin
        par_ok = ~(^{shreg, par_bit});
    end
`else
    // No parity bit on the line, so every stop-bit-clean frame is good.
    always_comb begin
        par_ok = 1'b1;
    end
`endif

    // Next-state logic: count to mid-bit, sample rxs, advance through the frame.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        idx_nxt   = idx;
        shreg_nxt = shreg;
        push      = 1'b0;
        ferr_nxt  = 1'b0;
        perr_nxt  = 1'b0;
`ifdef RX_PARITY_EN
        par_bit_nxt = par_bit;
`endif
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rxs) state_nxt = START;
            end
            START: begin
                // Half a bit in: confirm the start bit, otherwise treat it as a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt        = '0;
                    shreg_nxt[idx] = rxs;
                    if (idx == IDX_LAST) begin
`ifdef RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt     = '0;
                    par_bit_nxt = rxs;
                    state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                // Framing error wins over parity error; only a clean frame is pushed.
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (!rxs)        ferr_nxt = 1'b1;
                    else if (!par_ok) perr_nxt = 1'b1;
                    else             push     = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Registered one-cycle error pulses, aligned with the cycle valid would rise.
    always_ff @(posedge wb_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_err  <= ferr_nxt;
            parity_err <= perr_nxt;
            overflow   <= push && !fifo_wr_rdy;
        end
    end

    sync_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .core_clk (wb_clk),
        .arst_n   (rst_n),
        .wr_vld   (push),
        .wr_dat   (shreg_nxt),
        .wr_rdy   (fifo_wr_rdy),
        .rd_vld   (valid),
        .rd_rdy   (rd_en),
        .rd_dat   (data_out),
        .level    (count)
    );
endmodule
